md5_block_engine: RTL and testbench
===================================

# md5_block_engine

Iterative MD5 compression engine. It accepts one 512-bit message block plus a 128-bit chaining state through a valid/ready handshake. It runs all 64 MD5 rounds over several clock cycles, evaluating ROUNDS_PER_CYCLE rounds per cycle, and returns the updated chaining state through a second valid/ready handshake. It is the sequential successor to the single combinational round stage and is the unit a multi-block MD5 hasher wraps.

## Interface
- ROUNDS_PER_CYCLE, default 1: rounds evaluated per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start_valid  input  1  a request is presented.
- start_ready  output  1  engine is idle and can accept a request.
- state_in  input  128  chaining state {d,c,b,a}; a is at [31:0].
- message  input  512  16 words; word i is at [32i+31:32i].
- result_valid  output  1  state_out holds a completed result.
- result_ready  input  1  the consumer accepts the result.
- state_out  output  128  {d,c,b,a} after compression.
- busy  output  1  high in RUN.

## Operation
- FSM states and transitions:
  - IDLE: start_ready=1. start_valid&&start_ready latches state_in into the working and saved registers, latches message, clears round counter r to 0, and moves to RUN.
  - RUN: each cycle applies rounds r .. r+ROUNDS_PER_CYCLE-1 and sets r += ROUNDS_PER_CYCLE. When the last applied round is 63, moves to DONE.
  - DONE: result_valid=1 and state_out is the registered result. result_ready moves to IDLE.
- Round i (32-bit arithmetic, mod 2^32):
  - F: i<16 (b&c)|(~b&d); i<32 (b&d)|(c&~d); i<48 b^c^d; else c^(b|~d).
  - Message index g: i; (5i+1)%16; (3i+5)%16; 7i%16 for the four groups respectively.
  - Shift s: {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21} per group, indexed i%4.
  - K[i] = floor(|sin(i+1)|·2^32), held in a 64-entry constant ROM.
  - Update: new b = b + rotl(a+F+K[i]+M[g], s); a←d, d←c, c←b.
- Rounds within one cycle are chained combinationally in index order.
- message and state_in are sampled only at acceptance. Changing them afterwards has no effect.
- r is 6 bits. It wraps to 0 only when passing through DONE and is never used past 63.

## Timing
- Reset values: start_ready=0 while rst is high and 1 the first cycle after release; result_valid=0, busy=0, state_out=0; FSM goes to IDLE.
- Accept edge E. RUN occupies edges E+1 .. E+64/ROUNDS_PER_CYCLE. result_valid rises after the last RUN edge. Latency is 64/ROUNDS_PER_CYCLE+1 cycles from acceptance to result_valid.
- result_valid and state_out are held stable until result_ready is sampled high. There is no timeout.
- start_ready is 0 in RUN and DONE. The next acceptance happens no earlier than the cycle after the result handshake, which gives one idle bubble.
- result_ready outside DONE is ignored. start_valid outside IDLE is ignored and the request is not queued.
- rst asserted mid-RUN or mid-DONE immediately (asynchronously) drops result_valid and busy, clears state_out and aborts the block. The pending result is lost.

## Configuration
- MD5_CHAIN_ADD_EN defined: state_out = final working state + saved input state, per word, mod 2^32. This is standard MD5 feed-forward.
- MD5_CHAIN_ADD_EN undefined: state_out = raw working state after round 63, with no feed-forward adder. The caller performs the addition.
- Latency is identical in both builds.

## Test plan
- MD5_CHAIN_ADD_EN, ROUNDS_PER_CYCLE=1, IV {10325476,98badcfe,efcdab89,67452301}, message word0=00000080, others 0 -> state_out {7e42f8ec,980980e9,04b2008f,d98c1dd4} ("" digest d41d8cd9…), result_valid exactly 65 cycles after acceptance.
- Same IV, word0=80636261, word14=00000018, others 0, ROUNDS_PER_CYCLE=4 -> state_out {727fe128,7d3f96d6,b04fd23c,98500190} ("abc"), latency 17 cycles.
- result_ready held low 20 cycles after result_valid -> state_out constant, start_ready=0, start_valid ignored. Release -> IDLE next cycle, then a second "abc" request completes correctly.
- Change message and state_in every cycle during RUN -> result identical to the "" case.
- rst pulsed at round 30 -> all outputs 0 and start_ready=1 after release. A new "" request yields the correct digest.
- MD5_CHAIN_ADD_EN undefined, "" vector -> each output word equals the digest word minus the IV word, mod 2^32.

Source files
------------

// File: rtl/md5_block_engine.sv
`default_nettype none
// ============================================================================
// Module   : md5_block_engine
// Purpose  : Iterative MD5 compression of one 512-bit block. A request
//            (state_in + message) is taken through a valid/ready handshake,
//            64 rounds run at ROUNDS_PER_CYCLE rounds per clock, and the
//            updated chaining state is returned through a second handshake.
// Ports    : clk, rst (async, active-high)
//            start_valid / start_ready / state_in[127:0] / message[511:0]
//            result_valid / result_ready / state_out[127:0]
//            busy (high while rounds are running)
// Params   : ROUNDS_PER_CYCLE in {1,2,4,8,16}
// Macro    : MD5_CHAIN_ADD_EN -- when defined, state_out includes the MD5
//            feed-forward add of the input chaining state; otherwise
//            state_out is the raw working state after round 63.
// Revision : 1.0 - initial release
// ============================================================================
module md5_block_engine #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [127:0] state_in,
    input  logic [511:0] message,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
              ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
            $error("md5_block_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_step = 6'(ROUNDS_PER_CYCLE);
    // Round counter value at the start of the final RUN cycle.
    localparam logic [5:0] c_last = 6'(64 - ROUNDS_PER_CYCLE);

    localparam logic [31:0] c_k [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Shift amounts, indexed by {group, round % 4}.
    localparam logic [4:0] c_s [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    // One MD5 round on {d,c,b,a}; returns {d',c',b',a'} = {c, b, b_new, d}.
    function automatic logic [127:0] md5_round(input logic [127:0] st,
                                               input logic [5:0]   i,
                                               input logic [511:0] m);
        logic [31:0] a, b, c, d, f, sum, rot;
        logic [3:0]  ii, g;
        logic [4:0]  s;
        a  = st[31:0];
        b  = st[63:32];
        c  = st[95:64];
        d  = st[127:96];
        ii = i[3:0];
        // Message index only depends on i mod 16, so 4-bit arithmetic wraps correctly.
        case (i[5:4])
            2'd0:    begin f = (b & c) | (~b & d); g = ii;                 end
            2'd1:    begin f = (b & d) | (c & ~d); g = ii * 4'd5 + 4'd1;   end
            2'd2:    begin f = b ^ c ^ d;          g = ii * 4'd3 + 4'd5;   end
            default: begin f = c ^ (b | ~d);       g = ii * 4'd7;          end
        endcase
        s   = c_s[{i[5:4], i[1:0]}];
        sum = a + f + c_k[i] + m[{g, 5'b0} +: 32];
        // s is always in 4..23, so neither shift degenerates.
        rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
        return {c, b, b + rot, d};
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    logic [5:0]     r_round;
    logic [127:0]   r_work;
    logic [511:0]   r_msg;
    logic [127:0]   r_out;
    logic [127:0]   w_chain;
    logic [127:0]   w_result;
    logic           w_accept;

    assign w_accept = start_valid && (r_state == S_IDLE);

    // Rounds of one cycle chained in index order.
    always_comb begin
        w_chain = r_work;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            w_chain = md5_round(w_chain, r_round + 6'(j), r_msg);
        end
    end

`ifdef MD5_CHAIN_ADD_EN
    logic [127:0] r_saved;
    assign w_result = {w_chain[127:96] + r_saved[127:96],
                       w_chain[95:64]  + r_saved[95:64],
                       w_chain[63:32]  + r_saved[63:32],
                       w_chain[31:0]   + r_saved[31:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_saved <= '0;
        end else if (w_accept) begin
            r_saved <= state_in;
        end
    end
`else
    assign w_result = w_chain;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_valid)         w_state_next = S_RUN;
            S_RUN:   if (r_round == c_last)   w_state_next = S_DONE;
            S_DONE:  if (result_ready)        w_state_next = S_IDLE;
            default:                          w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round <= '0;
            r_work  <= '0;
            r_msg   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work  <= state_in;
                        r_msg   <= message;
                        r_round <= '0;
                    end
                end
                S_RUN: begin
                    r_work  <= w_chain;
                    r_round <= r_round + c_step;
                    if (r_round == c_last) begin
                        r_out <= w_result;
                    end
                end
                S_DONE: begin
                    r_round <= '0;
                end
                default: begin
                    r_round <= '0;
                end
            endcase
        end
    end

    // Ready is forced low while reset is held, even though the FSM sits in IDLE.
    assign start_ready  = (r_state == S_IDLE) && !rst;
    assign result_valid = (r_state == S_DONE);
    assign busy         = (r_state == S_RUN);
    assign state_out    = r_out;

endmodule
`default_nettype wire

// File: tb/tb_md5_block_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_md5_block_engine
// Purpose  : Directed self-checking bench for md5_block_engine. Two
//            instances (1 and 4 rounds per cycle) share clock and reset.
//            Expected digests are the published MD5 values of "" and "abc";
//            without MD5_CHAIN_ADD_EN the IV is subtracted per word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md5_block_engine;

    logic         clk;
    logic         rst;
    logic         sv   [2];
    logic         sr   [2];
    logic [127:0] si   [2];
    logic [511:0] msg  [2];
    logic         rv   [2];
    logic         rr   [2];
    logic [127:0] so   [2];
    logic         bsy  [2];

    int total;
    int bad;

    localparam logic [127:0] c_iv        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] c_dig_empty = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [127:0] c_dig_abc   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

    md5_block_engine #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .start_valid(sv[0]), .start_ready(sr[0]), .state_in(si[0]), .message(msg[0]),
        .result_valid(rv[0]), .result_ready(rr[0]), .state_out(so[0]), .busy(bsy[0])
    );

    md5_block_engine #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .start_valid(sv[1]), .start_ready(sr[1]), .state_in(si[1]), .message(msg[1]),
        .result_valid(rv[1]), .result_ready(rr[1]), .state_out(so[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] expect_of(input logic [127:0] dig);
`ifdef MD5_CHAIN_ADD_EN
        return dig;
`else
        return {dig[127:96] - c_iv[127:96], dig[95:64] - c_iv[95:64],
                dig[63:32]  - c_iv[63:32],  dig[31:0]  - c_iv[31:0]};
`endif
    endfunction

    // Issues one request from posedge+1; returns latency counted from the
    // acceptance edge (inclusive) to the first cycle result_valid is seen.
    task automatic run_req(input int d, input logic [127:0] iv, input logic [511:0] m,
                           input bit scramble, output int lat, output logic [127:0] res);
        int n;
        si[d]  = iv;
        msg[d] = m;
        sv[d]  = 1'b1;
        @(posedge clk);
        #1;
        sv[d] = 1'b0;
        n = 1;
        while (!rv[d] && n < 200) begin
            if (scramble) begin
                si[d] = {$urandom, $urandom, $urandom, $urandom};
                for (int k = 0; k < 16; k++) msg[d][k*32 +: 32] = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
        end
        lat = n;
        res = so[d];
    endtask

    task automatic ack(input int d);
        rr[d] = 1'b1;
        @(posedge clk);
        #1;
        rr[d] = 1'b0;
    endtask

    logic [511:0] m_empty;
    logic [511:0] m_abc;
    logic [127:0] res;
    logic [127:0] held;
    int           lat;

    initial begin
        total = 0;
        bad   = 0;
        for (int d = 0; d < 2; d++) begin
            sv[d] = 1'b0; rr[d] = 1'b0; si[d] = '0; msg[d] = '0;
        end
        m_empty = '0;
        m_empty[31:0] = 32'h00000080;
        m_abc = '0;
        m_abc[31:0] = 32'h80636261;
        m_abc[14*32 +: 32] = 32'h00000018;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready1", 128'(sr[0]), 128'd0);
        chk("rst_ready4", 128'(sr[1]), 128'd0);
        chk("rst_valid1", 128'(rv[0]), 128'd0);
        chk("rst_busy1",  128'(bsy[0]), 128'd0);
        chk("rst_out1",   so[0], 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready1", 128'(sr[0]), 128'd1);
        chk("post_rst_ready4", 128'(sr[1]), 128'd1);

        // "" digest, 1 round/cycle
        run_req(0, c_iv, m_empty, 1'b0, lat, res);
        chk("empty_lat1", 128'(lat), 128'd65);
        chk("empty_dig1", res, expect_of(c_dig_empty));
        chk("done_ready1", 128'(sr[0]), 128'd0);
        chk("done_busy1",  128'(bsy[0]), 128'd0);
        ack(0);
        chk("ack_valid1", 128'(rv[0]), 128'd0);
        chk("ack_ready1", 128'(sr[0]), 128'd1);

        // "abc" digest, 4 rounds/cycle
        run_req(1, c_iv, m_abc, 1'b0, lat, res);
        chk("abc_lat4", 128'(lat), 128'd17);
        chk("abc_dig4", res, expect_of(c_dig_abc));
        ack(1);

        // Backpressure: hold result 20 cycles while a stray request is presented
        run_req(1, c_iv, m_abc, 1'b0, lat, res);
        held   = so[1];
        sv[1]  = 1'b1;
        si[1]  = '1;
        msg[1] = '1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("hold_out4", so[1], held);
        end
        chk("hold_valid4", 128'(rv[1]), 128'd1);
        chk("hold_ready4", 128'(sr[1]), 128'd0);
        sv[1] = 1'b0;
        ack(1);
        chk("rel_valid4", 128'(rv[1]), 128'd0);
        chk("rel_ready4", 128'(sr[1]), 128'd1);
        run_req(1, c_iv, m_abc, 1'b0, lat, res);
        chk("abc2_lat4", 128'(lat), 128'd17);
        chk("abc2_dig4", res, expect_of(c_dig_abc));
        ack(1);

        // Inputs scrambled during RUN must not matter
        run_req(0, c_iv, m_empty, 1'b1, lat, res);
        chk("scr_lat1", 128'(lat), 128'd65);
        chk("scr_dig1", res, expect_of(c_dig_empty));
        ack(0);
        si[0] = '0;
        msg[0] = '0;

        // Asynchronous reset at round 30
        si[0]  = c_iv;
        msg[0] = m_empty;
        sv[0]  = 1'b1;
        @(posedge clk);
        #1;
        sv[0] = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        chk("pre_abort_busy1", 128'(bsy[0]), 128'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy1",  128'(bsy[0]), 128'd0);
        chk("abort_valid1", 128'(rv[0]), 128'd0);
        chk("abort_out1",   so[0], 128'd0);
        chk("abort_out4",   so[1], 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready1", 128'(sr[0]), 128'd1);
        chk("abort_busy1b", 128'(bsy[0]), 128'd0);
        run_req(0, c_iv, m_empty, 1'b0, lat, res);
        chk("post_abort_lat1", 128'(lat), 128'd65);
        chk("post_abort_dig1", res, expect_of(c_dig_empty));
        ack(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
